map_level_display_ctrl: RTL and testbench



---
 rtl/map_level_display_ctrl_pkg.sv | 23 ++
 rtl/map_level_display_ctrl_if.sv | 26 ++
 rtl/map_level_display_ctrl_bcd_seq_converter.sv | 56 +++++
 rtl/map_level_display_ctrl.sv | 152 +++++++++++++++
 tb/tb_map_level_display_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/map_level_display_ctrl_pkg.sv
// Shared definitions for the floor-map overlay controller and its renderer.
// State encoding, BCD digit width, overlay colours and the double-dabble digit adjust.
package map_level_display_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StConv   = 2'd1;
  localparam state_t StAuto   = 2'd2;
  localparam state_t StManual = 2'd3;

  localparam int unsigned BcdDigitW = 4;

  // 12-bit RGB colours used by the map renderer
  localparam logic [11:0] MapBgColour    = 12'h112;
  localparam logic [11:0] MapFloorColour = 12'h4a4;
  localparam logic [11:0] MapDigitColour = 12'hfff;

  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/map_level_display_ctrl_if.sv
// Signal bundle between camera/physics logic and the map controller.
// master drives the floor/key/frame inputs; slave is the controller.
interface map_level_display_ctrl_if
  import map_level_display_ctrl_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH = 5,
  parameter int unsigned BCD_DIGITS  = 2
);
  logic                            frame_tick;
  logic [LEVEL_WIDTH-1:0]          camera_y;
  logic                            map_key;
  logic                            map_on;
  logic [BcdDigitW*BCD_DIGITS-1:0] level_bcd;
  logic                            bcd_valid;
  logic                            digit_visible;

  modport master (
    output frame_tick, camera_y, map_key,
    input  map_on, level_bcd, bcd_valid, digit_visible
  );

  modport slave (
    input  frame_tick, camera_y, map_key,
    output map_on, level_bcd, bcd_valid, digit_visible
  );
endinterface

// File: rtl/map_level_display_ctrl_bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// bcd is only meaningful in the cycle done is high (it is the final shift result).
module map_level_display_ctrl_bcd_seq_converter
  import map_level_display_ctrl_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH = 5,
  parameter int unsigned BCD_DIGITS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEVEL_WIDTH-1:0]          bin,
  output logic                            busy,
  output logic                            done,
  output logic [BcdDigitW*BCD_DIGITS-1:0] bcd
);
  localparam int unsigned BcdW = BcdDigitW * BCD_DIGITS;
  localparam int unsigned CntW = $clog2(LEVEL_WIDTH + 1);

  logic [LEVEL_WIDTH-1:0] sh_q;
  logic [BcdW-1:0]        acc_q, adj, acc_next;
  logic [CntW-1:0]        cnt_q;
  logic                   busy_q;

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      adj[d*BcdDigitW +: BcdDigitW] = dd_adjust(acc_q[d*BcdDigitW +: BcdDigitW]);
    end
    acc_next = {adj[BcdW-2:0], sh_q[LEVEL_WIDTH-1]};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CntW'(1));
  assign bcd  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= bin;
      acc_q  <= '0;
      cnt_q  <= CntW'(LEVEL_WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sh_q  <= sh_q << 1;
      acc_q <= acc_next;
      cnt_q <= cnt_q - CntW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/map_level_display_ctrl.sv
// Floor-map overlay sequencer: timed auto display on floor change, manual toggle key,
// registered BCD floor digits. Optional digit blink in AUTO under MAP_LEVEL_BLINK_EN.
module map_level_display_ctrl
  import map_level_display_ctrl_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH  = 5,
  parameter int unsigned BCD_DIGITS   = 2,
  parameter int unsigned SHOW_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input logic                      clk,
  input logic                      rst_n,
  map_level_display_ctrl_if.slave  bus
);
  localparam int unsigned BcdW = BcdDigitW * BCD_DIGITS;

  state_t                 state_q, state_d, ret_q, ret_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   key_q;
  logic [LEVEL_WIDTH-1:0] latched_q;
  logic                   map_on_q, map_on_d;
  logic [BcdW-1:0]        bcd_q;
  logic                   valid_q;

  logic                   key_rise, lvl_chg, toggle;
  logic                   conv_busy, conv_done;
  logic [BcdW-1:0]        conv_bcd;

  map_level_display_ctrl_bcd_seq_converter #(
    .LEVEL_WIDTH (LEVEL_WIDTH),
    .BCD_DIGITS  (BCD_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (lvl_chg),
    .bin   (bus.camera_y),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    key_rise = bus.map_key & ~key_q;
    lvl_chg  = (state_q != StConv) && !conv_busy && (bus.camera_y != latched_q);
    toggle   = pend_q ^ key_rise;
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;

    case (state_q)
      StIdle, StAuto: begin
        if (lvl_chg) begin
          state_d = StConv;
          ret_d   = key_rise ? StManual : StAuto;
        end else if (key_rise) begin
          state_d = StManual;
        end else if ((state_q == StAuto) && bus.frame_tick) begin
          if (cnt_q == 8'd1) state_d = StIdle;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      StManual: begin
        if (lvl_chg) begin
          state_d = StConv;
          ret_d   = key_rise ? StIdle : StManual;
        end else if (key_rise) begin
          state_d = StIdle;
        end
      end
      StConv: begin
        // key edges during conversion fold into a parity toggle applied at done
        pend_d = toggle;
        if (conv_done) begin
          pend_d  = 1'b0;
          state_d = toggle ? ((ret_q == StManual) ? StIdle : StManual) : ret_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StAuto) && (state_q != StAuto)) cnt_d = 8'(SHOW_FRAMES);

    map_on_d = (state_d == StConv) ? map_on_q
                                   : ((state_d == StAuto) || (state_d == StManual));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ret_q     <= StIdle;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      key_q     <= 1'b0;
      latched_q <= '0;
      map_on_q  <= 1'b0;
      bcd_q     <= '0;
      valid_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      key_q    <= bus.map_key;
      map_on_q <= map_on_d;
      if (lvl_chg) begin
        latched_q <= bus.camera_y;
        valid_q   <= 1'b0;
      end
      if (conv_done) begin
        bcd_q   <= conv_bcd;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.map_on    = map_on_q;
  assign bus.level_bcd = bcd_q;
  assign bus.bcd_valid = valid_q;

`ifdef MAP_LEVEL_BLINK_EN
  logic [7:0] blink_cnt_q;
  logic       vis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
    end else if ((state_d == StAuto) && (state_q != StAuto)) begin
      blink_cnt_q <= 8'(BLINK_FRAMES);
      vis_q       <= 1'b1;
    end else if ((state_d == StAuto) && (state_q == StAuto)) begin
      if (bus.frame_tick) begin
        if (blink_cnt_q == 8'd1) begin
          vis_q       <= ~vis_q;
          blink_cnt_q <= 8'(BLINK_FRAMES);
        end else begin
          blink_cnt_q <= blink_cnt_q - 8'd1;
        end
      end
    end else begin
      vis_q <= 1'b1;
    end
  end

  assign bus.digit_visible = vis_q;
`else
  assign bus.digit_visible = 1'b1;
`endif

endmodule

// File: tb/tb_map_level_display_ctrl.sv
// Directed self-checking bench for map_level_display_ctrl (BLINK_FRAMES=2).
// Expected values are hand-derived; blink pattern depends on MAP_LEVEL_BLINK_EN.
module tb_map_level_display_ctrl;
  logic clk;
  logic rst_n;
  int   vec;
  int   miscmp;

  map_level_display_ctrl_if #(.LEVEL_WIDTH(5), .BCD_DIGITS(2)) bus ();

  map_level_display_ctrl #(
    .LEVEL_WIDTH  (5),
    .BCD_DIGITS   (2),
    .SHOW_FRAMES  (120),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic key_pulse();
    bus.map_key = 1'b1;
    step();
    bus.map_key = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.camera_y   = 5'd0;
    bus.map_key    = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL rst_map_on: got %b, expected 0", bus.map_on); end
    vec++; if (bus.level_bcd !== 8'h00) begin miscmp++; $display("FAIL rst_bcd: got %h, expected 00", bus.level_bcd); end
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL rst_valid: got %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.digit_visible !== 1'b1) begin miscmp++; $display("FAIL rst_vis: got %b, expected 1", bus.digit_visible); end
    rst_n = 1'b1;
    repeat (3) step();
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL idle_no_conv: valid %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL idle_map_on: got %b, expected 0", bus.map_on); end
  endtask

  task automatic test_auto_show();
    bus.camera_y = 5'd23;
    step();
    vec++; if (bus.bcd_valid !== 1'b0) begin miscmp++; $display("FAIL auto_c1_valid: got %b, expected 0", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL auto_c1_map_on: got %b, expected 0", bus.map_on); end
    repeat (4) step();
    vec++; if (bus.bcd_valid !== 1'b0) begin miscmp++; $display("FAIL auto_c5_valid: got %b, expected 0", bus.bcd_valid); end
    step();
    vec++; if (bus.level_bcd !== 8'h23) begin miscmp++; $display("FAIL auto_bcd: got %h, expected 23", bus.level_bcd); end
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL auto_valid: got %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL auto_map_on: got %b, expected 1", bus.map_on); end
    repeat (119) tick();
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL auto_tick119: map_on %b, expected 1", bus.map_on); end
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL auto_tick120: map_on %b, expected 0", bus.map_on); end
    step();
  endtask

  task automatic test_manual_key();
    key_pulse();
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL man_on: got %b, expected 1", bus.map_on); end
    for (int i = 0; i < 500; i++) begin
      tick();
      if (i % 100 == 99) begin
        vec++;
        if (bus.map_on !== 1'b1) begin
          miscmp++; $display("FAIL man_hold tick %0d: map_on %b, expected 1", i + 1, bus.map_on);
        end
      end
    end
    key_pulse();
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL man_off: got %b, expected 0", bus.map_on); end
    step();
    key_pulse();
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL man_reon: got %b, expected 1", bus.map_on); end
    step();
  endtask

  task automatic test_level_in_manual();
    bus.camera_y = 5'd31;
    for (int i = 1; i <= 5; i++) begin
      step();
      vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL lm_map_on c%0d: got %b, expected 1", i, bus.map_on); end
      vec++; if (bus.bcd_valid !== 1'b0) begin miscmp++; $display("FAIL lm_valid c%0d: got %b, expected 0", i, bus.bcd_valid); end
    end
    step();
    chk("lm_bcd", bus.level_bcd, 8'h31);
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL lm_valid_done: got %b, expected 1", bus.bcd_valid); end
    step();
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL lm_back_manual: got %b, expected 1", bus.map_on); end
    key_pulse();
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL lm_exit: got %b, expected 0", bus.map_on); end
    step();
  endtask

  task automatic test_pending_toggle();
    bus.camera_y = 5'd5;
    repeat (6) step();
    chk("pt_bcd5", bus.level_bcd, 8'h05);
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL pt_auto5: got %b, expected 1", bus.map_on); end
    key_pulse();
    step();
    key_pulse();
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL pt_idle: got %b, expected 0", bus.map_on); end
    step();
    bus.camera_y = 5'd9;
    step();
    vec++; if (bus.bcd_valid !== 1'b0) begin miscmp++; $display("FAIL pt_conv9: got %b, expected 0", bus.bcd_valid); end
    key_pulse();
    repeat (4) step();
    chk("pt_bcd9", bus.level_bcd, 8'h09);
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL pt_valid9: got %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL pt_map_on9: got %b, expected 1", bus.map_on); end
    step();
    key_pulse();
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL pt_was_manual: got %b, expected 0", bus.map_on); end
    step();
    bus.camera_y = 5'd20;
    step();
    step();
    bus.camera_y = 5'd12;
    repeat (4) step();
    chk("pt_bcd20", bus.level_bcd, 8'h20);
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL pt_valid20: got %b, expected 1", bus.bcd_valid); end
    step();
    vec++; if (bus.bcd_valid !== 1'b0) begin miscmp++; $display("FAIL pt_reconv: got %b, expected 0", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL pt_reconv_on: got %b, expected 1", bus.map_on); end
    repeat (5) step();
    chk("pt_bcd12", bus.level_bcd, 8'h12);
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL pt_valid12: got %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b1) begin miscmp++; $display("FAIL pt_auto12: got %b, expected 1", bus.map_on); end
  endtask

  task automatic test_blink_and_async_reset();
    logic [5:0] exp_vis;
`ifdef MAP_LEVEL_BLINK_EN
    exp_vis = 6'b110011;
`else
    exp_vis = 6'b111111;
`endif
    vec++;
    if (bus.digit_visible !== exp_vis[0]) begin
      miscmp++; $display("FAIL blink tick 0: got %b, expected %b", bus.digit_visible, exp_vis[0]);
    end
    for (int k = 1; k < 6; k++) begin
      tick();
      vec++;
      if (bus.digit_visible !== exp_vis[k]) begin
        miscmp++; $display("FAIL blink tick %0d: got %b, expected %b", k, bus.digit_visible, exp_vis[k]);
      end
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL async_map_on: got %b, expected 0", bus.map_on); end
    chk("async_bcd", bus.level_bcd, 8'h00);
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL async_valid: got %b, expected 1", bus.bcd_valid); end
    bus.camera_y = 5'd0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    vec++; if (bus.bcd_valid !== 1'b1) begin miscmp++; $display("FAIL post_rst_valid: got %b, expected 1", bus.bcd_valid); end
    vec++; if (bus.map_on !== 1'b0) begin miscmp++; $display("FAIL post_rst_map_on: got %b, expected 0", bus.map_on); end
  endtask

  initial begin
    vec    = 0;
    miscmp = 0;
    test_reset();
    test_auto_show();
    test_manual_key();
    test_level_in_manual();
    test_pending_toggle();
    test_blink_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
